// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared types and helpers for the instruction-fetch stage.
// Also used by if_stage_icache, which is only built when IF_ICACHE_EN is defined.
package if_stage_pkg;

    localparam int INST_W      = 32;
    localparam int ADDR_W      = 32;
    localparam int WORD_ADDR_W = ADDR_W - 2;  // word address, byte offset dropped

    typedef logic [ADDR_W-1:0] inst_addr_t;
    typedef logic [INST_W-1:0] inst_t;

    typedef enum logic {
        IF_FETCH = 1'b0,  // issuing / receiving the four bytes of a word
        IF_HOLD  = 1'b1   // word presented, waiting for downstream to take it
    } if_state_e;

    // Drop one byte into lane idx of a word (lane 0 = bits 7:0, little-endian).
    function automatic inst_t insert_byte(input inst_t word, input logic [1:0] idx,
                                          input logic [7:0] data);
        inst_t res;
        res              = word;
        res[8*idx +: 8]  = data;
        return res;
    endfunction

endpackage

// File: rtl/if_stage_icache.sv
// if_stage_icache: direct-mapped instruction cache, one 32-bit word per line.
// Combinational lookup, fill on a single-cycle strobe. Instantiated by if_stage
// only when IF_ICACHE_EN is defined.
module if_stage_icache
    import if_stage_pkg::*;
#(
    parameter int LINES = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WORD_ADDR_W-1:0] lookup_word_i,
    output logic                   hit_o,
    output inst_t                  hit_data_o,
    input  logic                   fill_en_i,
    input  logic [WORD_ADDR_W-1:0] fill_word_i,
    input  inst_t                  fill_data_i
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = WORD_ADDR_W - IDX_W;

    logic [LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_q  [LINES];
    inst_t            data_q [LINES];

    logic [IDX_W-1:0] lookup_idx, fill_idx;
    logic [TAG_W-1:0] lookup_tag, fill_tag;

    assign lookup_idx = lookup_word_i[IDX_W-1:0];
    assign lookup_tag = lookup_word_i[WORD_ADDR_W-1:IDX_W];
    assign fill_idx   = fill_word_i[IDX_W-1:0];
    assign fill_tag   = fill_word_i[WORD_ADDR_W-1:IDX_W];

    assign hit_o      = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
    assign hit_data_o = data_q[lookup_idx];

    // Mark the filled line valid.
    always_comb begin
        valid_d = valid_q;
        if (fill_en_i) begin
            valid_d[fill_idx] = 1'b1;
        end
    end

    // Valid bits: cleared on reset so every line starts as a miss.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag/data storage written on fill.
    // NOTE: tag/data arrays carry no reset; a cleared valid bit already masks stale contents.
    always_ff @(posedge clk) begin
        if (fill_en_i) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= fill_data_i;
        end
    end

endmodule

// File: rtl/if_stage.sv
// if_stage: RV32I instruction fetch over a shared byte-wide memory port.
// Four byte reads per word, assembled little-endian and presented with a
// valid/stall handshake; branch_flag_i redirects from any state.
// Optional direct-mapped I-cache: define IF_ICACHE_EN.
module if_stage
    import if_stage_pkg::*;
#(
    parameter inst_addr_t RESET_PC     = 32'h0000_0000,
    parameter int         ICACHE_LINES = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             branch_flag_i,
    input  logic [31:0]      branch_target_addr_i,
    output logic             mem_req_o,
    output logic [31:0]      mem_addr_o,
    input  logic             mem_gnt_i,
    input  logic [7:0]       mem_din_i,
    output logic [31:0]      pc_o,
    output logic [31:0]      inst_o,
    output logic             inst_valid_o
);

    if_state_e  state_q, state_d;
    inst_addr_t pc_q, pc_d;
    inst_t      inst_q, inst_d;
    logic       valid_q, valid_d;
    logic [2:0] issue_cnt_q, issue_cnt_d;  // bytes requested, 0..4
    logic [1:0] recv_cnt_q, recv_cnt_d;    // next byte lane to fill
    logic       pend_q, pend_d;            // a granted byte arrives this cycle

    logic       fetch_start;  // first cycle of a fetch, nothing issued yet
    logic       cache_hit;
    inst_t      cache_data;
    logic       use_hit;      // serve this fetch from the cache
    logic       mem_req;
    logic       last_byte;    // byte 3 is captured on this edge

    assign fetch_start = (state_q == IF_FETCH) && (issue_cnt_q == 3'd0) &&
                         (recv_cnt_q == 2'd0) && !pend_q;

`ifdef IF_ICACHE_EN
    logic cache_fill;

    assign cache_fill = !rst && last_byte;

    if_stage_icache #(
        .LINES(ICACHE_LINES)
    ) u_icache (
        .clk          (clk),
        .rst          (rst),
        .lookup_word_i(pc_q[ADDR_W-1:2]),
        .hit_o        (cache_hit),
        .hit_data_o   (cache_data),
        .fill_en_i    (cache_fill),
        .fill_word_i  (pc_q[ADDR_W-1:2]),
        .fill_data_i  (inst_d)
    );
`else
    // ICACHE_LINES only matters when the cache is built in.
    logic [31:0] unused_icache_lines;
    assign unused_icache_lines = 32'(ICACHE_LINES);
    assign cache_hit           = 1'b0;
    assign cache_data          = '0;
`endif

    // A redirect in the same cycle cancels a hit.
    assign use_hit   = fetch_start && cache_hit && !branch_flag_i;
    assign last_byte = (state_q == IF_FETCH) && pend_q && (recv_cnt_q == 2'd3) &&
                       !branch_flag_i && !use_hit;

    // Byte request: only in FETCH with bytes left, never during reset, a redirect or a hit.
    always_comb begin
        mem_req = 1'b0;
        if (!rst && !branch_flag_i && !use_hit &&
            (state_q == IF_FETCH) && (issue_cnt_q < 3'd4)) begin
            mem_req = 1'b1;
        end
    end

    assign mem_req_o    = mem_req;
    assign mem_addr_o   = rst ? '0 : pc_q + {29'd0, issue_cnt_q};
    assign pc_o         = pc_q;
    assign inst_o       = inst_q;
    assign inst_valid_o = valid_q;

    // Next-state logic: request/receive in FETCH, handshake in HOLD, redirect overrides both.
    // NOTE: every _d starts from its _q value so no path leaves it unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        valid_d     = valid_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        pend_d      = mem_req && mem_gnt_i;

        if (mem_req && mem_gnt_i) begin
            issue_cnt_d = issue_cnt_q + 3'd1;
        end

        case (state_q)
            IF_FETCH: begin
                if (use_hit) begin
                    inst_d  = cache_data;
                    valid_d = 1'b1;
                    state_d = IF_HOLD;
                end else if (pend_q) begin
                    inst_d     = insert_byte(inst_q, recv_cnt_q, mem_din_i);
                    recv_cnt_d = recv_cnt_q + 2'd1;
                    if (recv_cnt_q == 2'd3) begin
                        valid_d = 1'b1;
                        state_d = IF_HOLD;
                    end
                end
            end
            IF_HOLD: begin
                if (!stall_i) begin
                    pc_d        = pc_q + 32'd4;
                    valid_d     = 1'b0;
                    issue_cnt_d = 3'd0;
                    recv_cnt_d  = 2'd0;
                    pend_d      = 1'b0;
                    state_d     = IF_FETCH;
                end
            end
            default: state_d = IF_FETCH;
        endcase

        if (branch_flag_i) begin
            pc_d        = branch_target_addr_i;
            valid_d     = 1'b0;
            issue_cnt_d = 3'd0;
            recv_cnt_d  = 2'd0;
            pend_d      = 1'b0;
            state_d     = IF_FETCH;
        end
    end

    // State registers with synchronous reset.
    // NOTE: only this block assigns the flops, and only with <=; always_comb above uses =.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IF_FETCH;
            pc_q        <= RESET_PC;
            inst_q      <= '0;
            valid_q     <= 1'b0;
            issue_cnt_q <= 3'd0;
            recv_cnt_q  <= 2'd0;
            pend_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            valid_q     <= valid_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            pend_q      <= pend_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: self-checking bench for if_stage. Acts as the byte memory
// (granted byte returned on the following cycle) and checks directed timing
// scenarios plus a randomized run against a word-level fetch model.
`timescale 1ns/1ps
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_addr_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic [7:0]  mem_din_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;

    if_stage #(
        .RESET_PC    (RESET_PC),
        .ICACHE_LINES(64)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .stall_i             (stall_i),
        .branch_flag_i       (branch_flag_i),
        .branch_target_addr_i(branch_target_addr_i),
        .mem_req_o           (mem_req_o),
        .mem_addr_o          (mem_addr_o),
        .mem_gnt_i           (mem_gnt_i),
        .mem_din_i           (mem_din_i),
        .pc_o                (pc_o),
        .inst_o              (inst_o),
        .inst_valid_o        (inst_valid_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Byte memory, indexed by the low 10 address bits (addresses alias every 1 KiB).
    logic [7:0] mem [0:1023];

    // Outputs sampled mid-cycle by tick().
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_inst;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        return mem[a[9:0]];
    endfunction

    // Little-endian word starting at byte address a, byte addresses wrap mod 2^32.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] r;
        logic [31:0] t;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            t = a + 32'(k);
            r[8*k +: 8] = mem_byte(t);
        end
        return r;
    endfunction

    // One clock cycle. Inputs are set by the caller just after a negedge; outputs
    // are sampled 1 ns later, and the byte for a grant in this cycle is driven at
    // the next negedge so it is stable for the following posedge.
    task automatic tick();
        logic        g;
        logic [31:0] ga;
        #1;
        s_req   = mem_req_o;
        s_addr  = mem_addr_o;
        s_valid = inst_valid_o;
        s_pc    = pc_o;
        s_inst  = inst_o;
        g       = mem_req_o & mem_gnt_i;
        ga      = mem_addr_o;
        @(negedge clk);
        mem_din_i = g ? mem_byte(ga) : 8'($urandom);
        cyc++;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        stall_i       = 1'b0;
        branch_flag_i = 1'b0;
        mem_gnt_i     = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        do_reset();
        stall_i   = 1'b1;
        mem_gnt_i = 1'b1;
        tick();
        checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h0 || s_valid !== 1'b0 ||
            s_pc !== RESET_PC || s_inst !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: req=%b addr=%h valid=%b pc=%h inst=%h want req=1 addr=0 valid=0 pc=%h inst=0",
                     s_req, s_addr, s_valid, s_pc, s_inst, RESET_PC);
        end
        tick();
        tick();
        // Reset in the middle of a fetch: port gated, state cleared.
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (s_req !== 1'b0 || s_addr !== 32'h0) begin
                errors++;
                $display("FAIL reset_gating: req=%b addr=%h want req=0 addr=0", s_req, s_addr);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if (s_valid !== 1'b0 || s_pc !== RESET_PC || s_inst !== 32'h0 || s_req !== 1'b1 || s_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_midfetch_state: valid=%b pc=%h inst=%h req=%b addr=%h want 0/%h/0/1/0",
                     s_valid, s_pc, s_inst, s_req, s_addr, RESET_PC);
        end
        n = 1;
        do begin tick(); n++; end while (!s_valid && n < 20);
        checks++;
        if (n !== 6 || s_inst !== 32'h0000_0093 || s_pc !== RESET_PC) begin
            errors++;
            $display("FAIL reset_refetch: valid in c%0d inst=%h pc=%h want c5 inst=00000093 pc=%h",
                     n - 1, s_inst, s_pc, RESET_PC);
        end
    endtask

    task automatic test_min_latency();
        do_reset();
        stall_i   = 1'b1;
        mem_gnt_i = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (s_req !== (c < 4) || (c < 4 && s_addr !== 32'(c)) || s_valid !== (c == 5)) begin
                errors++;
                $display("FAIL min_latency c%0d: req=%b addr=%h valid=%b want req=%b addr=%0d valid=%b",
                         c, s_req, s_addr, s_valid, c < 4, c, c == 5);
            end
        end
        checks++;
        if (s_inst !== 32'h0000_0093 || s_pc !== 32'h0) begin
            errors++;
            $display("FAIL min_latency_word: inst=%h pc=%h want 00000093 / 0", s_inst, s_pc);
        end
    endtask

    task automatic test_gnt_wait();
        int first_valid;
        do_reset();
        stall_i     = 1'b1;
        first_valid = -1;
        for (int c = 0; c < 16; c++) begin
            mem_gnt_i = !(c >= 1 && c <= 3);
            tick();
            if (c >= 1 && c <= 3) begin
                checks++;
                if (s_req !== 1'b1 || s_addr !== 32'h1) begin
                    errors++;
                    $display("FAIL gnt_wait_hold c%0d: req=%b addr=%h want req=1 addr=1", c, s_req, s_addr);
                end
            end
            if (s_valid && first_valid < 0) first_valid = c;
        end
        checks++;
        if (first_valid !== 8 || s_inst !== 32'h0000_0093 || s_pc !== 32'h0) begin
            errors++;
            $display("FAIL gnt_wait_word: valid at c%0d inst=%h pc=%h want c8 00000093 / 0",
                     first_valid, s_inst, s_pc);
        end
        mem_gnt_i = 1'b1;
    endtask

    task automatic test_stall();
        int n;
        do_reset();
        stall_i   = 1'b1;
        mem_gnt_i = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!s_valid && n < 20);
        checks++;
        if (!s_valid) begin
            errors++;
            $display("FAIL stall_timeout: no valid within %0d cycles", n);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (s_valid !== 1'b1 || s_req !== 1'b0 || s_pc !== 32'h0 || s_inst !== 32'h0000_0093) begin
                errors++;
                $display("FAIL stall_hold %0d: valid=%b req=%b pc=%h inst=%h want 1/0/0/00000093",
                         i, s_valid, s_req, s_pc, s_inst);
            end
        end
        stall_i = 1'b0;
        tick();
        stall_i = 1'b1;
        tick();
        checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h4 || s_pc !== 32'h4 || s_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: req=%b addr=%h pc=%h valid=%b want 1/4/4/0",
                     s_req, s_addr, s_pc, s_valid);
        end
    endtask

    task automatic test_branch();
        do_reset();
        stall_i   = 1'b1;
        mem_gnt_i = 1'b1;
        tick();
        tick();
        tick();
        branch_flag_i        = 1'b1;
        branch_target_addr_i = 32'h100;
        tick();
        checks++;
        if (s_req !== 1'b0) begin
            errors++;
            $display("FAIL branch_req_gated: req=%b want 0", s_req);
        end
        branch_flag_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (s_req !== 1'b1 || s_addr !== 32'h100 + 32'(k)) begin
                errors++;
                $display("FAIL branch_addr %0d: req=%b addr=%h want 1/%h", k, s_req, s_addr, 32'h100 + 32'(k));
            end
        end
        tick();
        tick();
        checks++;
        if (s_valid !== 1'b1 || s_pc !== 32'h100 || s_inst !== word_at(32'h100)) begin
            errors++;
            $display("FAIL branch_word: valid=%b pc=%h inst=%h want 1/00000100/%h",
                     s_valid, s_pc, s_inst, word_at(32'h100));
        end
    endtask

    task automatic test_branch_stall();
        int n;
        do_reset();
        stall_i   = 1'b1;
        mem_gnt_i = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!s_valid && n < 20);
        branch_flag_i        = 1'b1;
        branch_target_addr_i = 32'h200;
        tick();
        checks++;
        if (s_req !== 1'b0) begin
            errors++;
            $display("FAIL branch_stall_req: req=%b want 0", s_req);
        end
        branch_flag_i = 1'b0;
        tick();
        checks++;
        if (s_valid !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h200 || s_pc !== 32'h200) begin
            errors++;
            $display("FAIL branch_stall_redirect: valid=%b req=%b addr=%h pc=%h want 0/1/200/200",
                     s_valid, s_req, s_addr, s_pc);
        end
        n = 0;
        do begin tick(); n++; end while (!s_valid && n < 20);
        checks++;
        if (s_valid !== 1'b1 || s_inst !== word_at(32'h200)) begin
            errors++;
            $display("FAIL branch_stall_word: valid=%b inst=%h want 1/%h", s_valid, s_inst, word_at(32'h200));
        end
    endtask

    task automatic test_wrap();
        int n;
        do_reset();
        stall_i              = 1'b1;
        mem_gnt_i            = 1'b1;
        branch_flag_i        = 1'b1;
        branch_target_addr_i = 32'hFFFF_FFFC;
        tick();
        branch_flag_i = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!s_valid && n < 20);
        checks++;
        if (s_valid !== 1'b1 || s_pc !== 32'hFFFF_FFFC || s_inst !== word_at(32'hFFFF_FFFC)) begin
            errors++;
            $display("FAIL wrap_word: valid=%b pc=%h inst=%h want 1/fffffffc/%h",
                     s_valid, s_pc, s_inst, word_at(32'hFFFF_FFFC));
        end
        stall_i = 1'b0;
        tick();
        stall_i = 1'b1;
        tick();
        checks++;
        if (s_pc !== 32'h0 || s_req !== 1'b1 || s_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_pc: pc=%h req=%b addr=%h want 0/1/0", s_pc, s_req, s_addr);
        end
    endtask

`ifdef IF_ICACHE_EN
    task automatic test_cache();
        int n;
        do_reset();
        stall_i   = 1'b1;
        mem_gnt_i = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!s_valid && n < 20);
        branch_flag_i        = 1'b1;
        branch_target_addr_i = 32'h0;
        tick();
        branch_flag_i = 1'b0;
        tick();
        checks++;
        if (s_req !== 1'b0 || s_valid !== 1'b0) begin
            errors++;
            $display("FAIL cache_hit_cycle: req=%b valid=%b want 0/0", s_req, s_valid);
        end
        tick();
        checks++;
        if (s_valid !== 1'b1 || s_req !== 1'b0 || s_inst !== 32'h0000_0093 || s_pc !== 32'h0) begin
            errors++;
            $display("FAIL cache_hit_word: valid=%b req=%b inst=%h pc=%h want 1/0/00000093/0",
                     s_valid, s_req, s_inst, s_pc);
        end
        do_reset();
        tick();
        checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h0) begin
            errors++;
            $display("FAIL cache_reset_miss: req=%b addr=%h want 1/0", s_req, s_addr);
        end
    endtask
`endif

    // Randomized run against a word-level model: the stream of presented words
    // must follow pc+4 on consumption, jump on redirect, restart on reset, and
    // each word must equal the memory contents at its pc.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic        prev_hold;
        int          wait_cnt;
        int          words;
        do_reset();
        exp_pc    = RESET_PC;
        prev_hold = 1'b0;
        wait_cnt  = 0;
        words     = 0;
        for (int c = 0; c < 3000; c++) begin
            rst                  = ($urandom % 400) == 0;
            branch_flag_i        = ($urandom % 40) == 0;
            branch_target_addr_i = $urandom;
            if ($urandom % 4 != 0) branch_target_addr_i[1:0] = 2'b00;
            stall_i   = ($urandom % 3) == 0;
            mem_gnt_i = ($urandom % 4) != 0;
            tick();
            if (prev_hold) begin
                checks++;
                if (s_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL rand_hold_drop c%0d: valid=%b want 1", cyc, s_valid);
                end
            end
            if (s_valid) begin
                words++;
                checks++;
                if (s_pc !== exp_pc || s_inst !== word_at(exp_pc) || wait_cnt > 60) begin
                    errors++;
                    $display("FAIL rand_word c%0d: pc=%h inst=%h wait=%0d want pc=%h inst=%h wait<=60",
                             cyc, s_pc, s_inst, wait_cnt, exp_pc, word_at(exp_pc));
                end
            end
            if (rst || branch_flag_i || s_valid) begin
                checks++;
                if (s_req !== 1'b0 || (rst && s_addr !== 32'h0)) begin
                    errors++;
                    $display("FAIL rand_req_gated c%0d: req=%b addr=%h rst=%b br=%b valid=%b want req=0",
                             cyc, s_req, s_addr, rst, branch_flag_i, s_valid);
                end
            end else if (s_req) begin
                checks++;
                if (s_addr - exp_pc > 32'd3) begin
                    errors++;
                    $display("FAIL rand_req_addr c%0d: addr=%h want within %h..+3", cyc, s_addr, exp_pc);
                end
            end
            if (rst) begin
                exp_pc = RESET_PC;
            end else if (branch_flag_i) begin
                exp_pc = branch_target_addr_i;
            end else if (s_valid && !stall_i) begin
                exp_pc = exp_pc + 32'd4;
            end
            prev_hold = s_valid && stall_i && !branch_flag_i && !rst;
            wait_cnt  = (s_valid || rst || branch_flag_i) ? 0 : wait_cnt + 1;
        end
        rst           = 1'b0;
        branch_flag_i = 1'b0;
        checks++;
        if (words < 100) begin
            errors++;
            $display("FAIL rand_progress: words=%0d want >=100", words);
        end
    endtask

    initial begin
        rst                  = 1'b1;
        stall_i              = 1'b0;
        branch_flag_i        = 1'b0;
        branch_target_addr_i = 32'h0;
        mem_gnt_i            = 1'b0;
        mem_din_i            = 8'h00;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h93;
        mem[1] = 8'h00;
        mem[2] = 8'h00;
        mem[3] = 8'h00;
        @(negedge clk);
        test_reset();
        test_min_latency();
        test_gnt_wait();
        test_stall();
        test_branch();
        test_branch_stall();
        test_wrap();
`ifdef IF_ICACHE_EN
        test_cache();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
